// File: rtl/mag_comp_pkg.sv
// ============================================================================
// mag_comp_pkg : FSM state type and one-hot result encodings for mag_comp_seq
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mag_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot result flags, ordered {gt, eq, lt}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage

`default_nettype wire

// File: rtl/mag_chunk_cmp.sv
// ============================================================================
// mag_chunk_cmp : combinational W-bit unsigned compare producing gt / lt
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mag_chunk_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

`default_nettype wire

// File: rtl/mag_comp_seq.sv
// ============================================================================
// mag_comp_seq : sequential N-bit magnitude comparator, CHUNK bits per cycle,
//                MSB chunk first. Define MAG_COMP_EARLY_EXIT_EN to finish on
//                the first differing chunk instead of a fixed NCH cycles.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mag_comp_seq
    import mag_comp_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] ip1,
    input  logic [N-1:0] ip2,
    input  logic         is_signed,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         ip1_gt_ip2,
    output logic         ip1_eq_ip2,
    output logic         ip1_lt_ip2
);

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCH        = N / SAFE_CHUNK;
    localparam int CW         = $clog2(NCH + 1);
    localparam logic [N-1:0] MSB_MASK = {{(N-1){1'b0}}, 1'b1} << (N - 1);

    generate
        if ((CHUNK < 1) || ((N % SAFE_CHUNK) != 0)) begin : g_bad_param
            $error("mag_comp_seq: N must be a multiple of CHUNK and CHUNK >= 1");
        end
    endgenerate

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   op1_sr;
    logic [N-1:0]   op2_sr;
    logic [N-1:0]   op1_shift;
    logic [N-1:0]   op2_shift;
    logic [CW-1:0]  cnt;
    logic           diff_found;
    logic           diff_gt;
    logic [2:0]     res_flags;
    logic           chunk_gt;
    logic           chunk_lt;
    logic           accept;
    logic           last_step;
    logic           leave_cmp;
    logic           found_nx;
    logic           gt_nx;

    mag_chunk_cmp #(
        .W (CHUNK)
    ) u_chunk_cmp (
        .a  (op1_sr[N-1 -: CHUNK]),
        .b  (op2_sr[N-1 -: CHUNK]),
        .gt (chunk_gt),
        .lt (chunk_lt)
    );

    generate
        if (NCH > 1) begin : g_shift
            assign op1_shift = {op1_sr[N-CHUNK-1:0], {CHUNK{1'b0}}};
            assign op2_shift = {op2_sr[N-CHUNK-1:0], {CHUNK{1'b0}}};
        end else begin : g_no_shift
            assign op1_shift = '0;
            assign op2_shift = '0;
        end
    endgenerate

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign res_valid   = (state == DONE);
    assign accept      = start_valid && (state == IDLE);
    assign last_step   = (cnt == CW'(1));

    // The first differing chunk decides the result; later chunks cannot override it
    assign found_nx    = diff_found | chunk_gt | chunk_lt;
    assign gt_nx       = diff_found ? diff_gt : chunk_gt;

`ifdef MAG_COMP_EARLY_EXIT_EN
    assign leave_cmp   = last_step | chunk_gt | chunk_lt;
`else
    assign leave_cmp   = last_step;
`endif

    assign ip1_gt_ip2  = res_flags[2];
    assign ip1_eq_ip2  = res_flags[1];
    assign ip1_lt_ip2  = res_flags[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = CMP;
            CMP:     if (leave_cmp) state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Signed mode flips both MSBs (offset binary) so the unsigned chunk compare covers it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_sr     <= '0;
            op2_sr     <= '0;
            cnt        <= '0;
            diff_found <= 1'b0;
            diff_gt    <= 1'b0;
            res_flags  <= '0;
        end else if (accept) begin
            op1_sr     <= ip1 ^ (is_signed ? MSB_MASK : '0);
            op2_sr     <= ip2 ^ (is_signed ? MSB_MASK : '0);
            cnt        <= CW'(NCH);
            diff_found <= 1'b0;
            diff_gt    <= 1'b0;
            res_flags  <= '0;
        end else if (state == CMP) begin
            op1_sr     <= op1_shift;
            op2_sr     <= op2_shift;
            cnt        <= cnt - CW'(1);
            diff_found <= found_nx;
            diff_gt    <= gt_nx;
            if (leave_cmp) begin
                res_flags <= found_nx ? (gt_nx ? RES_GT : RES_LT) : RES_EQ;
            end
        end
    end

endmodule

`default_nettype wire
